// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump reader.
package reg_dump_pkg;

    localparam int REG_IDX_W  = 4;
    localparam int REG_NREG   = 1 << REG_IDX_W;
    localparam int REG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0]  idx;
        logic [REG_DATA_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/reg_mask_pick2.sv
// Picks the two lowest set bits of a register mask (combinational).
module reg_mask_pick2
    import reg_dump_pkg::*;
#(
    parameter int NREG  = REG_NREG,
    parameter int IDX_W = REG_IDX_W
) (
    input  logic [NREG-1:0]  mask,
    output logic [IDX_W-1:0] a,
    output logic             a_vld,
    output logic [IDX_W-1:0] b,
    output logic             b_vld
);

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves the second candidate as the new lowest.
    logic [NREG-1:0] rest;
    assign rest  = mask & (mask - NREG'(1));

    assign a     = lowest_set(mask);
    assign a_vld = |mask;
    assign b     = lowest_set(rest);
    assign b_vld = |rest;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register mask, reads two bank registers per access and streams
// {index, value} words to a valid/ready consumer in ascending index order.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NREG     = REG_NREG,
    parameter int IDX_W    = REG_IDX_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NREG-1:0]   mask,
    output logic [IDX_W-1:0]  rd_sel1,
    output logic [IDX_W-1:0]  rd_sel2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(READ_LAT + 1);

    state_t           state, next_state;
    logic [NREG-1:0]  pending;
    logic [IDX_W-1:0] pick_a, pick_b;
    logic             pick_a_vld, pick_b_vld;
    logic             pair_q;
    logic [CNT_W-1:0] wait_cnt;
    buf_entry_t       entry [2];
    logic [1:0]       ent_vld;
    logic [1:0]       ent_last;
    logic             head;
    logic             fire, drain_empty, wait_done;

    reg_mask_pick2 #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask  (pending),
        .a     (pick_a),
        .a_vld (pick_a_vld),
        .b     (pick_b),
        .b_vld (pick_b_vld)
    );

    assign fire        = out_valid && out_ready;
    assign drain_empty = fire && !(!head && ent_vld[1]);
    // Bank data for the select issued on entry to WAIT is sampled READ_LAT+1 edges later.
    assign wait_done   = (wait_cnt == CNT_W'(READ_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (mask != '0) ? ISSUE : DONE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_done) next_state = DRAIN;
            DRAIN:   if (drain_empty) next_state = pick_a_vld ? ISSUE : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_valid = ent_vld[head];
        out_data  = entry[head].data;
        out_idx   = entry[head].idx;
        out_last  = ent_vld[head] && ent_last[head];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            rd_sel1  <= '0;
            rd_sel2  <= '0;
            pair_q   <= 1'b0;
            wait_cnt <= '0;
            entry[0] <= '0;
            entry[1] <= '0;
            ent_vld  <= '0;
            ent_last <= '0;
            head     <= 1'b0;
        end else if (abort) begin
            pending  <= '0;
            wait_cnt <= '0;
            ent_vld  <= '0;
            ent_last <= '0;
            head     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) pending <= mask;
                end
                ISSUE: begin
                    rd_sel1          <= pick_a;
                    rd_sel2          <= pick_b_vld ? pick_b : pick_a;
                    pair_q           <= pick_b_vld;
                    pending[pick_a]  <= 1'b0;
                    if (pick_b_vld) pending[pick_b] <= 1'b0;
                    wait_cnt         <= '0;
                end
                WAIT: begin
                    if (wait_done) begin
                        // pending already excludes this pair, so an empty mask marks the tail.
                        entry[0]    <= '{idx: rd_sel1, data: rd_data1};
                        ent_vld[0]  <= 1'b1;
                        ent_last[0] <= !pick_a_vld && !pair_q;
                        if (pair_q) begin
                            entry[1]    <= '{idx: rd_sel2, data: rd_data2};
                            ent_vld[1]  <= 1'b1;
                            ent_last[1] <= !pick_a_vld;
                        end
                        head <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        ent_vld[head] <= 1'b0;
                        head          <= !head && ent_vld[1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader against a registered register-bank model.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] mask_in;
    logic [3:0]  rd_sel1, rd_sel2;
    logic [31:0] rd_data1, rd_data2;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last, busy, done;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;

    always #5 clk = ~clk;

    reg_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mask      (mask_in),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Bank model: r[i] = A000_0000 + i, one registered cycle of read latency.
    always @(posedge clk) begin
        rd_data1 <= 32'hA000_0000 + 32'(rd_sel1);
        rd_data2 <= 32'hA000_0000 + 32'(rd_sel2);
        cyc      <= cyc + 1;
    end

    // Scoreboard: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && out_valid && out_ready && !abort) begin
            exp_t e;
            hs_cnt++;
            last_hs_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got idx=%0d data=%h, expected no word", out_idx, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_idx, out_data, out_last} !== {e.idx, e.data, e.last}) begin
                    errors++;
                    $display("FAIL sb_word: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                             out_idx, out_data, out_last, e.idx, e.data, e.last);
                end
            end
        end
    end

    task automatic start_dump(input logic [15:0] m);
        int hi;
        @(posedge clk); #1;
        hi = -1;
        for (int i = 0; i < 16; i++) if (m[i]) hi = i;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) exp_q.push_back('{idx: 4'(i), data: 32'hA000_0000 + 32'(i), last: (i == hi)});
        end
        mask_in = m;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done_pulse(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/last/busy/done=%b, expected 0000", {out_valid, out_last, busy, done});
        end
        checks++;
        if ({rd_sel1, rd_sel2, out_idx, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got sel1=%0d sel2=%0d idx=%0d data=%h, expected all 0", rd_sel1, rd_sel2, out_idx, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_mask;
        int hs0, dn0, lat;
        bit seen;
        hs0 = hs_cnt; dn0 = done_cnt; out_ready = 1'b1;
        start_dump(16'hFFFF);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL full_first_latency: got %0d cycles, expected 3", lat);
        end
        wait_done_pulse(200, seen);
        checks++;
        if (!seen || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_done: got seen=%b busy=%b, expected seen=1 busy=1", seen, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_fall: got busy=%b done=%b, expected 0 0", busy, done);
        end
        checks++;
        if (hs_cnt - hs0 !== 16 || done_cnt - dn0 !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL full_counts: got words=%0d dones=%0d left=%0d, expected 16 1 0",
                     hs_cnt - hs0, done_cnt - dn0, exp_q.size());
        end
    endtask

    task automatic test_pair_ends;
        int hs0;
        bit seen;
        hs0 = hs_cnt; out_ready = 1'b1;
        start_dump(16'h8001);
        @(posedge clk); #1;
        checks++;
        if (rd_sel1 !== 4'd0 || rd_sel2 !== 4'd15) begin
            errors++;
            $display("FAIL pair_sel: got sel1=%0d sel2=%0d, expected 0 15", rd_sel1, rd_sel2);
        end
        wait_done_pulse(100, seen);
        checks++;
        if (!seen || cyc - last_hs_cyc !== 1) begin
            errors++;
            $display("FAIL pair_done_timing: got seen=%b gap=%0d, expected seen=1 gap=1", seen, cyc - last_hs_cyc);
        end
        @(posedge clk); #1;
        checks++;
        if (hs_cnt - hs0 !== 2 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pair_counts: got words=%0d left=%0d, expected 2 0", hs_cnt - hs0, exp_q.size());
        end
    endtask

    task automatic test_single_and_empty;
        int hs0, dn0;
        bit seen, saw_valid;
        hs0 = hs_cnt; out_ready = 1'b1;
        start_dump(16'h0004);
        @(posedge clk); #1;
        checks++;
        if (rd_sel1 !== 4'd2 || rd_sel2 !== 4'd2) begin
            errors++;
            $display("FAIL single_sel: got sel1=%0d sel2=%0d, expected 2 2", rd_sel1, rd_sel2);
        end
        wait_done_pulse(100, seen);
        @(posedge clk); #1;
        checks++;
        if (!seen || hs_cnt - hs0 !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_counts: got seen=%b words=%0d left=%0d, expected 1 1 0", seen, hs_cnt - hs0, exp_q.size());
        end
        // Empty mask goes straight to DONE without presenting any word.
        hs0 = hs_cnt; dn0 = done_cnt;
        start_dump(16'h0000);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got done=%b valid=%b, expected 1 0", done, out_valid);
        end
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || busy !== 1'b0 || done_cnt - dn0 !== 1 || hs_cnt != hs0) begin
            errors++;
            $display("FAIL empty_quiet: got valid_seen=%b busy=%b dones=%0d words=%0d, expected 0 0 1 0",
                     saw_valid, busy, done_cnt - dn0, hs_cnt - hs0);
        end
    endtask

    task automatic test_backpressure;
        int hs0, stall_err;
        bit seen, pv, pr, pl;
        logic [31:0] pd;
        logic [3:0]  pi;
        hs0 = hs_cnt; stall_err = 0; seen = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0;
        start_dump(16'h00F0);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi || out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b idx=%0d data=%h last=%b, expected v=1 idx=%0d data=%h last=%b",
                             out_valid, out_idx, out_data, out_last, pi, pd, pl);
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!seen || hs_cnt - hs0 !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_counts: got seen=%b words=%0d left=%0d, expected 1 4 0", seen, hs_cnt - hs0, exp_q.size());
        end
    endtask

    task automatic test_abort;
        int hs0, dn0;
        bit found, seen;
        out_ready = 1'b1; hs0 = hs_cnt; dn0 = done_cnt; found = 1'b0;
        @(posedge clk); #1;
        mask_in = 16'hFFFF; start = 1'b1;
        exp_q.push_back('{idx: 4'd0, data: 32'hA000_0000, last: 1'b0});
        exp_q.push_back('{idx: 4'd1, data: 32'hA000_0001, last: 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid && hs_cnt - hs0 == 2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found || out_idx !== 4'd2) begin
            errors++;
            $display("FAIL abort_third: got found=%b idx=%0d, expected 1 2", found, out_idx);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b, expected 0 0 0", busy, out_valid, done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != dn0 || hs_cnt - hs0 !== 2 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got dones=%0d words=%0d left=%0d, expected 0 2 0", done_cnt - dn0, hs_cnt - hs0, exp_q.size());
        end
        hs0 = hs_cnt;
        start_dump(16'hFFFF);
        wait_done_pulse(200, seen);
        @(posedge clk); #1;
        checks++;
        if (!seen || hs_cnt - hs0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_restart: got seen=%b words=%0d left=%0d, expected 1 16 0", seen, hs_cnt - hs0, exp_q.size());
        end
    endtask

    task automatic test_midwait_reset;
        int hs0, dn0;
        bit seen;
        out_ready = 1'b1;
        @(posedge clk); #1;
        mask_in = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_sel1, rd_sel2, out_idx, out_data, out_valid, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got sel1=%0d sel2=%0d valid=%b busy=%b data=%h, expected all 0",
                     rd_sel1, rd_sel2, out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        hs0 = hs_cnt; dn0 = done_cnt;
        start_dump(16'hFFFF);
        repeat (8) @(posedge clk);
        #1;
        mask_in = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done_pulse(200, seen);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (!seen || hs_cnt - hs0 !== 16 || done_cnt - dn0 !== 1 || busy !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL busy_start: got seen=%b words=%0d dones=%0d busy=%b left=%0d, expected 1 16 1 0 0",
                     seen, hs_cnt - hs0, done_cnt - dn0, busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_pair_ends();
        test_single_and_empty();
        test_backpressure();
        test_abort();
        test_midwait_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
